serial_rx: RTL and testbench

- Laser-link serial receiver: the downstream stage that consumes the bitstream from the link transmitter.
- Detects and validates a start bit, samples PKT_LENGTH data bits LSB-first at mid-bit, then checks the stop bit.
- Presents each completed word with a one-cycle new_data strobe to the packet/decode logic.
- Line framing is fixed: idle = 0, start = 1, data LSB-first, stop = 0.

---
 rtl/serial_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/serial_rx.sv | 164 ++++++++++++++++
 tb/tb_serial_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared laser-link serial definitions (rx states, line levels, default baud)
package serial_pkg;

    // Receiver state encoding
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        ERR_WAIT = 3'd4
    } rx_state_e;

    // Line levels of the link framing
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

    // Clocks per bit at the 65 MHz system clock
    localparam int CLK_PER_BIT_65MHZ = 13540;

    // Two-of-three vote used for glitch-tolerant sampling
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterizable-width two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; only sync_q is safe to use in the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - laser-link serial receiver; SERIAL_RX_MAJORITY_EN enables 3-sample majority voting
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_65MHZ,
    parameter int PKT_LENGTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [PKT_LENGTH-1:0] data,
    output logic                  new_data,
    output logic                  busy,
    output logic                  frame_error
);

    localparam int CTR_SIZE     = $clog2(CLK_PER_BIT);
    localparam int BIT_CTR_SIZE = $clog2(PKT_LENGTH) + 1;

    localparam logic [CTR_SIZE-1:0]     CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0]     CTR_FULL = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [BIT_CTR_SIZE-1:0] BIT_LAST = BIT_CTR_SIZE'(PKT_LENGTH - 1);

    logic rx_s;
    logic sample;

    rx_state_e state_q, state_d;
    logic [CTR_SIZE-1:0]     ctr_q, ctr_d;
    logic [BIT_CTR_SIZE-1:0] bit_ctr_q, bit_ctr_d;
    logic [PKT_LENGTH-1:0]   shreg_q, shreg_d;
    logic [PKT_LENGTH-1:0]   data_q, data_d;
    logic                    new_data_q, new_data_d;
    logic                    frame_error_q, frame_error_d;

    logic half_hit;
    logic full_hit;
    logic last_bit;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    assign half_hit = (ctr_q == CTR_HALF);
    assign full_hit = (ctr_q == CTR_FULL);
    assign last_bit = (bit_ctr_q == BIT_LAST);

`ifdef SERIAL_RX_MAJORITY_EN
    // Last two rx_s values; with the live value they span terminal-2..terminal
    logic [1:0] hist_q;

    // Shift rx_s history every cycle so the vote is ready at any terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = majority3(hist_q[1], hist_q[0], rx_s);
`else
    assign sample = rx_s;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: framing decisions at the terminal counts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rx_s == LINE_START) state_d = START;
            START:    if (half_hit) state_d = (sample == LINE_START) ? DATA : IDLE;
            DATA:     if (full_hit && last_bit) state_d = STOP;
            STOP:     if (full_hit) state_d = (sample == LINE_STOP) ? IDLE : ERR_WAIT;
            ERR_WAIT: if (rx_s == LINE_IDLE) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output/datapath logic: bit timing, shifting and the result strobes
    always_comb begin
        ctr_d         = ctr_q + 1'b1;
        bit_ctr_d     = bit_ctr_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        new_data_d    = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
            end
            START: begin
                if (half_hit) begin
                    ctr_d     = '0;
                    bit_ctr_d = '0;
                end
            end
            DATA: begin
                if (full_hit) begin
                    ctr_d = '0;
                    shreg_d[bit_ctr_q[BIT_CTR_SIZE-2:0]] = sample;
                    bit_ctr_d = bit_ctr_q + 1'b1;
                end
            end
            STOP: begin
                if (full_hit) begin
                    ctr_d = '0;
                    if (sample == LINE_STOP) begin
                        data_d     = shreg_q;
                        new_data_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            ERR_WAIT: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
            end
            default: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
            end
        endcase
    end

    // Datapath registers; reset aborts any frame in flight without strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q         <= '0;
            bit_ctr_q     <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            new_data_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            ctr_q         <= ctr_d;
            bit_ctr_q     <= bit_ctr_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            new_data_q    <= new_data_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data        = data_q;
    assign new_data    = new_data_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - scoreboard testbench for serial_rx with a behavioural line model
module tb_serial_rx;
    import serial_pkg::*;

    localparam int CPB     = 16;
    localparam int PKT     = 32;
    localparam int HALF_P  = 5;
    localparam int LATENCY = CPB / 2 + (PKT + 1) * CPB + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b0;
    logic [31:0] data;
    logic        new_data;
    logic        busy;
    logic        frame_error;

    serial_rx #(
        .CLK_PER_BIT(CPB),
        .PKT_LENGTH (PKT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .new_data   (new_data),
        .busy       (busy),
        .frame_error(frame_error)
    );

    always #HALF_P clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] word;
        longint      t0;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    longint      mon_lat;
    logic [31:0] last_good = 32'h0;
    int          checks   = 0;
    int          failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops one expected event and is compared against it
    always @(negedge clk) begin
        if (new_data || frame_error) begin
            check1("strobe_exclusive", new_data & frame_error, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: new_data=%b frame_error=%b expected no strobe",
                         new_data, frame_error);
            end else begin
                mon_e = exp_q.pop_front();
                check1("strobe_is_error", frame_error, mon_e.is_err);
                if (!mon_e.is_err) begin
                    check32("rx_word", data, mon_e.word);
                    mon_lat = ($time - mon_e.t0) / (2 * HALF_P);
                    checks++;
                    if (mon_lat < LATENCY - 1 || mon_lat > LATENCY + 1) begin
                        failures++;
                        $display("FAIL latency: got %0d clk expected %0d+-1 clk", mon_lat, LATENCY);
                    end
                    last_good = mon_e.word;
                end else begin
                    check32("err_data_held", data, last_good);
                end
            end
        end
    end

    // Transmit one frame on rx; optional glitch cycle, mid-frame reset, bad stop bit
    task automatic send_frame(input logic [31:0] w, input logic [31:0] exp_w, input bit bad_stop,
                              input int glitch_cyc, input int abort_cyc, input int gap);
        bit   lvls[$];
        exp_t e;
        int   total;
        bit   lvl;
        lvls.push_back(LINE_START);
        for (int i = 0; i < PKT; i++) lvls.push_back(w[i]);
        if (bad_stop) begin
            for (int i = 0; i < 3; i++) lvls.push_back(1'b1);
        end else begin
            lvls.push_back(LINE_STOP);
        end
        total = lvls.size() * CPB;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0 && abort_cyc < 0) begin
                e.is_err = bad_stop;
                e.word   = exp_w;
                e.t0     = $time;
                exp_q.push_back(e);
            end
            if (c == abort_cyc) begin
                rx  = LINE_IDLE;
                rst = 1'b1;
                @(negedge clk);
                check32("rst_mid_data", data, 32'h0);
                check1("rst_mid_new_data", new_data, 1'b0);
                check1("rst_mid_busy", busy, 1'b0);
                check1("rst_mid_frame_error", frame_error, 1'b0);
                rst       = 1'b0;
                last_good = 32'h0;
                return;
            end
            if (c == 3 * CPB) check1("busy_mid_frame", busy, 1'b1);
            lvl = lvls[c / CPB];
            if (c == glitch_cyc) lvl = !lvl;
            rx = lvl;
        end
        if (bad_stop) check1("busy_err_wait", busy, 1'b1);
        @(negedge clk);
        rx = LINE_IDLE;
        if (!bad_stop) check1("busy_after_stop", busy, 1'b0);
        repeat (gap) @(negedge clk);
        if (bad_stop) check1("busy_after_line_low", busy, 1'b0);
    endtask

    // Short high pulse that must be rejected as a false start
    task automatic false_start();
        @(negedge clk);
        rx = LINE_START;
        repeat (4) @(negedge clk);
        check1("busy_false_start", busy, 1'b1);
        rx = LINE_IDLE;
        repeat (11) @(negedge clk);
        check1("busy_after_false_start", busy, 1'b0);
        check32("data_after_false_start", data, last_good);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] glitch_exp;
        bit          bad;
        rst = 1'b1;
        rx  = LINE_IDLE;
        repeat (3) @(negedge clk);
        check32("reset_data", data, 32'h0);
        check1("reset_new_data", new_data, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_frame_error", frame_error, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, -1, -1, 5);
        false_start();
        send_frame(32'h12345678, 32'h12345678, 1'b1, -1, -1, 6);
        send_frame(32'h0000FFFF, 32'h0000FFFF, 1'b0, -1, -1, 5);
        send_frame(32'h00000001, 32'h00000001, 1'b0, -1, -1, 0);
        send_frame(32'h80000000, 32'h80000000, 1'b0, -1, -1, 5);
        send_frame($urandom, 32'h0, 1'b0, -1, 11 * CPB + 5, 5);
        send_frame(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, -1, -1, 5);

`ifdef SERIAL_RX_MAJORITY_EN
        glitch_exp = 32'h00000000;
`else
        glitch_exp = 32'h00000001;
`endif
        send_frame(32'h00000000, glitch_exp, 1'b0, CPB + CPB / 2, -1, 5);

        for (int n = 0; n < 10; n++) begin
            w   = $urandom;
            bad = ($urandom_range(0, 3) == 0);
            send_frame(w, w, bad, -1, -1, bad ? 6 : int'($urandom_range(0, 8)));
        end

        repeat (50) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
